// File: rtl/lstm_config_regfile.sv
// lstm_config_regfile
// ---------------------------------------------------------------------------
// Memory-mapped configuration register file for the LSTM datapath. It holds
// the layer/weight/bias configuration words and a CONTROL register that
// launches the LSTM engine.
//
// Register map (byte addresses):
//   OFFSET + 4*i, i = 0 .. NUM_REGS-2 : data registers (R/W, byte strobes)
//   OFFSET + 4*(NUM_REGS-1)           : CONTROL
//                                       bit0 START (write-1 pulse, reads 0)
//                                       bit1 BUSY  (read-only)
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. A response transfers on a rising edge where
// resp_valid and resp_ready are both high. Only one request can be
// outstanding. req_ready depends on the FSM state only, never on req_valid.
// resp_rdata and resp_error stay stable while resp_valid is high.
//
// Ports:
//   clk, reset_n            clock (rising edge), synchronous active-low reset
//   req_valid/req_ready     request handshake
//   req_write               1 = write, 0 = read
//   req_addr                byte address
//   req_wdata/req_wstrb     write data and per-byte write strobes
//   resp_valid/resp_ready   response handshake
//   resp_rdata              read data (0 for writes and errors)
//   resp_error              request rejected (bad address or START while busy)
//   regs_flat               all data registers, register i at [i*DW +: DW]
//   reg_updated             one-cycle pulse per data register written
//   start                   one-cycle engine launch pulse
//   busy                    engine busy status
//
// The FSM state is held in state_q (IDLE/RESP) for checkers to bind to.
// ---------------------------------------------------------------------------
module lstm_config_regfile #(
  parameter logic [31:0] OFFSET     = 32'h0,
  parameter int          LAYERS     = 3,
  parameter int          WEIGHTS    = 4,
  parameter int          DATA_WIDTH = 32,
  localparam int         NUM_REGS   = 4 * (LAYERS * WEIGHTS) + 2 * LAYERS + 1,
  localparam int         NUM_DATA   = NUM_REGS - 1,
  localparam int         STRB_W     = DATA_WIDTH / 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [31:0]                    req_addr,
  input  logic [DATA_WIDTH-1:0]          req_wdata,
  input  logic [STRB_W-1:0]              req_wstrb,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [DATA_WIDTH-1:0]          resp_rdata,
  output logic                           resp_error,
  output logic [NUM_DATA*DATA_WIDTH-1:0] regs_flat,
  output logic [NUM_DATA-1:0]            reg_updated,
  output logic                           start,
  input  logic                           busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] regs_q [NUM_DATA];

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic [31:0]           addr_rel;
  logic [31:0]           idx;
  logic                  addr_err;
  logic                  is_ctrl;
  logic                  start_req;
  logic                  req_err;
  logic                  accept;
  logic                  data_we;
  logic [DATA_WIDTH-1:0] rd_data;

  always_comb begin
    addr_rel  = req_addr - OFFSET;
    idx       = addr_rel >> 2;
    // A below-base address wraps addr_rel, so it is flagged explicitly.
    addr_err  = (req_addr < OFFSET) || (req_addr[1:0] != 2'b00) ||
                (idx >= 32'(NUM_REGS));
    is_ctrl   = !addr_err && (idx == 32'(NUM_DATA));
    start_req = req_write && is_ctrl && req_wstrb[0] && req_wdata[0];
    // Launching while the engine is busy is rejected rather than queued.
    req_err   = addr_err || (start_req && busy);
    accept    = (state_q == IDLE) && req_valid;
    data_we   = accept && req_write && !addr_err && !is_ctrl;
  end

  // Read mux; CONTROL only exposes BUSY, START always reads back 0.
  always_comb begin
    rd_data = '0;
    if (!addr_err) begin
      if (is_ctrl) begin
        rd_data[1] = busy;
      end else begin
        for (int i = 0; i < NUM_DATA; i++) begin
          if (idx == 32'(i)) rd_data = regs_q[i];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Storage, response capture and pulses
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_DATA; i++) regs_q[i] <= '0;
      resp_rdata  <= '0;
      resp_error  <= 1'b0;
      reg_updated <= '0;
      start       <= 1'b0;
    end else begin
      // Pulses default low so they last exactly the cycle after accept.
      reg_updated <= '0;
      start       <= 1'b0;
      if (accept) begin
        resp_error <= req_err;
        resp_rdata <= (req_write || req_err) ? '0 : rd_data;
        start      <= start_req && !busy;
        for (int i = 0; i < NUM_DATA; i++) begin
          if (data_we && (idx == 32'(i))) begin
            // The pulse fires even with an all-zero strobe.
            reg_updated[i] <= 1'b1;
            for (int b = 0; b < STRB_W; b++) begin
              if (req_wstrb[b]) regs_q[i][b*8 +: 8] <= req_wdata[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_DATA; g++) begin : g_flat
    assign regs_flat[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

endmodule

// File: tb/tb_lstm_config_regfile.sv
// Testbench for lstm_config_regfile (default parameters: 55 registers,
// CONTROL at 0xD8) plus a second instance with OFFSET = 0x100.
module tb_lstm_config_regfile;

  localparam int NR = 55;
  localparam int ND = NR - 1;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic              req_valid, req_ready, req_write;
  logic [31:0]       req_addr;
  logic [DW-1:0]     req_wdata;
  logic [3:0]        req_wstrb;
  logic              resp_valid, resp_ready, resp_error;
  logic [DW-1:0]     resp_rdata;
  logic [ND*DW-1:0]  regs_flat;
  logic [ND-1:0]     reg_updated;
  logic              start, busy;

  logic              req_valid_b, req_ready_b, req_write_b;
  logic [31:0]       req_addr_b;
  logic [DW-1:0]     req_wdata_b;
  logic [3:0]        req_wstrb_b;
  logic              resp_valid_b, resp_ready_b, resp_error_b;
  logic [DW-1:0]     resp_rdata_b;
  logic [ND*DW-1:0]  regs_flat_b;
  logic [ND-1:0]     reg_updated_b;
  logic              start_b, busy_b;

  lstm_config_regfile u_dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error),
    .regs_flat(regs_flat), .reg_updated(reg_updated),
    .start(start), .busy(busy)
  );

  lstm_config_regfile #(.OFFSET(32'h100)) u_dut_off (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b), .req_wstrb(req_wstrb_b),
    .resp_valid(resp_valid_b), .resp_ready(resp_ready_b),
    .resp_rdata(resp_rdata_b), .resp_error(resp_error_b),
    .regs_flat(regs_flat_b), .reg_updated(reg_updated_b),
    .start(start_b), .busy(busy_b)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  logic [DW-1:0]    model_regs [ND];
  logic [ND*DW-1:0] model_flat;
  logic             exp_ready, exp_valid, exp_err, exp_start;
  logic [DW-1:0]    exp_rdata;
  logic [ND-1:0]    exp_upd;
  logic             chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Spec-level model of one accepted request (OFFSET = 0).
  task automatic model_accept(input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] strb,
                              input logic bsy);
    int idx;
    exp_rdata = '0;
    exp_err   = 1'b0;
    exp_upd   = '0;
    exp_start = 1'b0;
    idx = int'(addr >> 2);
    if (addr[1:0] != 2'b00 || addr >= 32'(4 * NR)) begin
      exp_err = 1'b1;
    end else if (idx == ND) begin
      if (wr) begin
        if (strb[0] && wdata[0]) begin
          if (bsy) exp_err = 1'b1;
          else     exp_start = 1'b1;
        end
      end else begin
        exp_rdata = bsy ? 32'h2 : 32'h0;
      end
    end else if (wr) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model_regs[idx][b*8 +: 8] = wdata[b*8 +: 8];
      exp_upd[idx] = 1'b1;
    end else begin
      exp_rdata = model_regs[idx];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ND; i++) model_regs[i] = '0;
    exp_ready = 1'b1;
    exp_valid = 1'b0;
    exp_upd   = '0;
    exp_start = 1'b0;
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", req_ready, exp_ready);
      check("resp_valid", resp_valid, exp_valid);
      check("reg_updated", reg_updated, exp_upd);
      check("start", start, exp_start);
      if (exp_valid) begin
        check("resp_rdata", resp_rdata, exp_rdata);
        check("resp_error", resp_error, exp_err);
      end
      for (int i = 0; i < ND; i++) model_flat[i*DW +: DW] = model_regs[i];
      n_cmp++;
      if (regs_flat !== model_flat) begin
        n_fail++;
        for (int i = 0; i < ND; i++) begin
          if (regs_flat[i*DW +: DW] !== model_regs[i]) begin
            $display("FAIL regs_flat reg %0d: got %0h expected %0h",
                     i, regs_flat[i*DW +: DW], model_regs[i]);
            break;
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle; returns at a negedge, idle again.
  task automatic do_req(input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input int hold, output logic [31:0] got_rd,
                        output logic got_err);
    req_write  = wr;
    req_addr   = addr;
    req_wdata  = wdata;
    req_wstrb  = strb;
    req_valid  = 1'b1;
    resp_ready = (hold == 0);
    @(posedge clk);
    model_accept(wr, addr, wdata, strb, busy);
    exp_valid = 1'b1;
    exp_ready = 1'b0;
    @(negedge clk);
    got_rd    = resp_rdata;
    got_err   = resp_error;
    req_valid = 1'b0;
    for (int h = 0; h < hold; h++) begin
      if (h == 1) begin
        // A request offered during RESP must be ignored.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'hFFFF_FFFF;
        req_wstrb = 4'hF;
      end
      @(posedge clk);
      exp_upd   = '0;
      exp_start = 1'b0;
      @(negedge clk);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    exp_upd   = '0;
    exp_start = 1'b0;
    exp_valid = 1'b0;
    exp_ready = 1'b1;
    @(negedge clk);
  endtask

  // Second instance: one request with resp_ready high, literal checks.
  task automatic do_req_b(input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic exp_e,
                          input logic [ND-1:0] exp_u, input string tag);
    req_write_b = wr;
    req_addr_b  = addr;
    req_wdata_b = wdata;
    req_wstrb_b = 4'hF;
    req_valid_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid_b = 1'b0;
    check({tag, "_valid"}, resp_valid_b, 1'b1);
    check({tag, "_error"}, resp_error_b, exp_e);
    check({tag, "_rdata"}, resp_rdata_b, 32'h0);
    check({tag, "_upd"}, reg_updated_b, exp_u);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_idle"}, resp_valid_b, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] rd;
  logic        er;

  initial begin
    reset_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_wstrb = '0; resp_ready = 1'b1; busy = 1'b0;
    req_valid_b = 1'b0; req_write_b = 1'b0; req_addr_b = '0;
    req_wdata_b = '0; req_wstrb_b = '0; resp_ready_b = 1'b1; busy_b = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    check("rst_start", start, 1'b0);

    // Full write, then read back.
    do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, rd, er);
    check("wr10_err", er, 1'b0);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
    check("rd10", rd, 32'hDEAD_BEEF);

    // Partial write over 0xDEADBEEF.
    do_req(1'b1, 32'h10, 32'h1122_3344, 4'h5, 0, rd, er);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
    check("rd10_partial", rd, 32'hDE22_BE44);
    check("model10_pin", model_regs[4], 32'hDE22_BE44);

    // Address errors.
    do_req(1'b0, 32'hDC, 32'h0, 4'h0, 0, rd, er);
    check("rd_dc_err", er, 1'b1);
    check("rd_dc_rdata", rd, 32'h0);
    do_req(1'b1, 32'hDC, 32'hFFFF_FFFF, 4'hF, 0, rd, er);
    check("wr_dc_err", er, 1'b1);
    do_req(1'b0, 32'h12, 32'h0, 4'h0, 0, rd, er);
    check("rd_12_err", er, 1'b1);
    do_req(1'b1, 32'h12, 32'hFFFF_FFFF, 4'hF, 0, rd, er);
    check("wr_12_err", er, 1'b1);

    // Zero strobe still pulses reg_updated; boundary registers.
    do_req(1'b1, 32'h0, 32'hFFFF_FFFF, 4'h0, 0, rd, er);
    do_req(1'b1, 32'hD4, 32'hCAFE_F00D, 4'hF, 0, rd, er);
    do_req(1'b0, 32'hD4, 32'h0, 4'h0, 0, rd, er);
    check("rd_d4", rd, 32'hCAFE_F00D);
    foreach (model_regs[i]) begin
      if (i == 0 || i == 1 || i == 20 || i == 33) begin
        do_req(1'b1, 32'(4 * i), 32'h0101_0101 * (i + 3), 4'hF, 0, rd, er);
        do_req(1'b0, 32'(4 * i), 32'h0, 4'h0, 0, rd, er);
      end
    end

    // CONTROL register.
    busy = 1'b0;
    do_req(1'b1, 32'hD8, 32'h1, 4'h1, 0, rd, er);
    check("start_err", er, 1'b0);
    busy = 1'b1;
    do_req(1'b1, 32'hD8, 32'h1, 4'h1, 0, rd, er);
    check("start_busy_err", er, 1'b1);
    do_req(1'b0, 32'hD8, 32'h0, 4'h0, 0, rd, er);
    check("rd_ctrl_busy", rd, 32'h2);
    busy = 1'b0;
    do_req(1'b0, 32'hD8, 32'h0, 4'h0, 0, rd, er);
    check("rd_ctrl_idle", rd, 32'h0);
    do_req(1'b1, 32'hD8, 32'h1, 4'h0, 0, rd, er);
    check("ctrl_noop_err", er, 1'b0);

    // Back-pressured response with an ignored second request.
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 5, rd, er);
    check("hold_rd", rd, 32'hDE22_BE44);

    // Reset while in RESP, then reset with a write presented.
    req_write = 1'b0; req_addr = 32'h10; req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clk);
    model_accept(1'b0, 32'h10, 32'h0, 4'h0, busy);
    exp_valid = 1'b1;
    exp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    reset_n = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10;
    req_wdata = 32'h5555_5555; req_wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset_n = 1'b1;
    resp_ready = 1'b1;
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_error", resp_error, 1'b0);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
    check("rd10_after_rst", rd, 32'h0);

    // OFFSET = 0x100 instance.
    do_req_b(1'b0, 32'h0C, 32'h0, 1'b1, '0, "off_below");
    do_req_b(1'b1, 32'h100, 32'hA5A5_A5A5, 1'b0, 54'h1, "off_wr0");
    check("off_reg0", regs_flat_b[31:0], 32'hA5A5_A5A5);
    do_req_b(1'b1, 32'h0C, 32'h1234_5678, 1'b1, '0, "off_wr_below");
    check("off_reg0_kept", regs_flat_b[31:0], 32'hA5A5_A5A5);
    check("off_reg3_kept", regs_flat_b[127:96], 32'h0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
